// File: rtl/fmul_axis_core.sv
// Single-precision IEEE-754 multiplier with AXI-Stream operand slots and result port.
// Three pipeline stages (product, normalize/round, output register) that all stall
// together while a valid result is waiting on the downstream consumer.
// Denormal inputs are flushed to zero and underflowing results are flushed to zero.
module fmul_axis_core (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] s_axis_a_tdata,
   input  logic        s_axis_a_tvalid,
   output logic        s_axis_a_tready,
   input  logic [31:0] s_axis_b_tdata,
   input  logic        s_axis_b_tvalid,
   output logic        s_axis_b_tready,
   output logic [31:0] m_axis_result_tdata,
   output logic        m_axis_result_tvalid,
   input  logic        m_axis_result_tready
);

   logic        a_full_q, a_full_d;
   logic [31:0] a_data_q, a_data_d;
   logic        b_full_q, b_full_d;
   logic [31:0] b_data_q, b_data_d;

   logic        stall, fire, a_load, b_load;

   logic        s1_valid_q, s1_valid_d;
   logic        s1_sign_q, s1_sign_d;
   logic        s1_special_q, s1_special_d;
   logic [31:0] s1_spec_val_q, s1_spec_val_d;
   logic [9:0]  s1_exp_q, s1_exp_d;
   logic [47:0] s1_prod_q, s1_prod_d;

   logic        s2_valid_q, s2_valid_d;
   logic [31:0] s2_res_q, s2_res_d;

   logic        out_valid_q, out_valid_d;
   logic [31:0] out_data_q, out_data_d;

   logic [7:0]  a_exp, b_exp;
   logic [22:0] a_frac, b_frac;
   logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
   logic        op_sign;

   logic [23:0] n_mant;
   logic        n_guard, n_sticky, round_up;
   logic [9:0]  n_exp, f_exp;
   logic [24:0] r_mant;
   logic [22:0] f_frac;

   assign m_axis_result_tdata  = out_data_q;
   assign m_axis_result_tvalid = out_valid_q;

   // Handshake: the whole pipe advances unless a result is stuck at the output.
   // Ready is forced low during reset and only looks at registers and downstream ready.
   always_comb begin
      stall           = out_valid_q & ~m_axis_result_tready;
      fire            = a_full_q & b_full_q & ~stall;
      s_axis_a_tready = ~rst & (~a_full_q | fire);
      s_axis_b_tready = ~rst & (~b_full_q | fire);
      a_load          = s_axis_a_tvalid & s_axis_a_tready;
      b_load          = s_axis_b_tvalid & s_axis_b_tready;
   end

   // Operand slots: cleared on fire, a same-edge refill wins so back-to-back ops flow.
   always_comb begin
      a_full_d = a_full_q;
      a_data_d = a_data_q;
      b_full_d = b_full_q;
      b_data_d = b_data_q;
      if (fire) begin
         a_full_d = 1'b0;
         b_full_d = 1'b0;
      end
      if (a_load) begin
         a_full_d = 1'b1;
         a_data_d = s_axis_a_tdata;
      end
      if (b_load) begin
         b_full_d = 1'b1;
         b_data_d = s_axis_b_tdata;
      end
   end

   // Stage 1: classify operands, form the 48-bit mantissa product and biased exponent sum.
   always_comb begin
      a_exp   = a_data_q[30:23];
      a_frac  = a_data_q[22:0];
      b_exp   = b_data_q[30:23];
      b_frac  = b_data_q[22:0];
      a_zero  = (a_exp == 8'h00);
      a_inf   = (a_exp == 8'hFF) && (a_frac == 23'd0);
      a_nan   = (a_exp == 8'hFF) && (a_frac != 23'd0);
      b_zero  = (b_exp == 8'h00);
      b_inf   = (b_exp == 8'hFF) && (b_frac == 23'd0);
      b_nan   = (b_exp == 8'hFF) && (b_frac != 23'd0);
      op_sign = a_data_q[31] ^ b_data_q[31];

      s1_valid_d    = s1_valid_q;
      s1_sign_d     = s1_sign_q;
      s1_special_d  = s1_special_q;
      s1_spec_val_d = s1_spec_val_q;
      s1_exp_d      = s1_exp_q;
      s1_prod_d     = s1_prod_q;

      if (!stall) begin
         s1_valid_d = fire;
         if (fire) begin
            s1_sign_d     = op_sign;
            s1_prod_d     = {24'd0, 1'b1, a_frac} * {24'd0, 1'b1, b_frac};
            s1_exp_d      = {2'b00, a_exp} + {2'b00, b_exp} - 10'd127;
            s1_special_d  = 1'b1;
            s1_spec_val_d = 32'd0;
            if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
               s1_spec_val_d = 32'h7FC0_0000;
            end else if (a_inf || b_inf) begin
               s1_spec_val_d = {op_sign, 8'hFF, 23'd0};
            end else if (a_zero || b_zero) begin
               s1_spec_val_d = {op_sign, 31'd0};
            end else begin
               s1_special_d  = 1'b0;
            end
         end
      end
   end

   // Stage 2: normalize, round to nearest even, then saturate to Inf or flush to zero.
   always_comb begin
      if (s1_prod_q[47]) begin
         n_mant   = s1_prod_q[47:24];
         n_guard  = s1_prod_q[23];
         n_sticky = |s1_prod_q[22:0];
         n_exp    = s1_exp_q + 10'd1;
      end else begin
         n_mant   = s1_prod_q[46:23];
         n_guard  = s1_prod_q[22];
         n_sticky = |s1_prod_q[21:0];
         n_exp    = s1_exp_q;
      end
      round_up = n_guard & (n_sticky | n_mant[0]);
      r_mant   = {1'b0, n_mant} + {24'd0, round_up};
      // a carry out can only come from an all-ones mantissa, so the shifted fraction is zero
      f_exp    = r_mant[24] ? n_exp + 10'd1 : n_exp;
      f_frac   = r_mant[24] ? r_mant[23:1] : r_mant[22:0];

      s2_valid_d = s2_valid_q;
      s2_res_d   = s2_res_q;
      if (!stall) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            if (s1_special_q) begin
               s2_res_d = s1_spec_val_q;
            end else if ($signed(f_exp) >= 10'sd255) begin
               s2_res_d = {s1_sign_q, 8'hFF, 23'd0};
            end else if ($signed(f_exp) <= 10'sd0) begin
               s2_res_d = {s1_sign_q, 31'd0};
            end else begin
               s2_res_d = {s1_sign_q, f_exp[7:0], f_frac};
            end
         end
      end
   end

   // Stage 3: output register, holds data and valid while downstream is not ready.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (!stall) begin
         out_valid_d = s2_valid_q;
         if (s2_valid_q) begin
            out_data_d = s2_res_q;
         end
      end
   end

   // State registers; reset discards every in-flight operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_full_q      <= 1'b0;
         a_data_q      <= 32'd0;
         b_full_q      <= 1'b0;
         b_data_q      <= 32'd0;
         s1_valid_q    <= 1'b0;
         s1_sign_q     <= 1'b0;
         s1_special_q  <= 1'b0;
         s1_spec_val_q <= 32'd0;
         s1_exp_q      <= 10'd0;
         s1_prod_q     <= 48'd0;
         s2_valid_q    <= 1'b0;
         s2_res_q      <= 32'd0;
         out_valid_q   <= 1'b0;
         out_data_q    <= 32'd0;
      end else begin
         a_full_q      <= a_full_d;
         a_data_q      <= a_data_d;
         b_full_q      <= b_full_d;
         b_data_q      <= b_data_d;
         s1_valid_q    <= s1_valid_d;
         s1_sign_q     <= s1_sign_d;
         s1_special_q  <= s1_special_d;
         s1_spec_val_q <= s1_spec_val_d;
         s1_exp_q      <= s1_exp_d;
         s1_prod_q     <= s1_prod_d;
         s2_valid_q    <= s2_valid_d;
         s2_res_q      <= s2_res_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
      end
   end

endmodule

// File: tb/tb_fmul_axis_core.sv
// Self-checking bench for fmul_axis_core: directed latency/skew/backpressure/reset
// sequences, a table of arithmetic corner cases, and randomized traffic against a
// reference model built on integer arithmetic.
module tb_fmul_axis_core;

   logic        clk;
   logic        rst;
   logic [31:0] a_data, b_data, m_data;
   logic        a_valid, a_ready, b_valid, b_ready, m_valid, m_ready;

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[19];

   fmul_axis_core dut (
      .clk                  (clk),
      .rst                  (rst),
      .s_axis_a_tdata       (a_data),
      .s_axis_a_tvalid      (a_valid),
      .s_axis_a_tready      (a_ready),
      .s_axis_b_tdata       (b_data),
      .s_axis_b_tvalid      (b_valid),
      .s_axis_b_tready      (b_ready),
      .m_axis_result_tdata  (m_data),
      .m_axis_result_tvalid (m_valid),
      .m_axis_result_tready (m_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %08h expected %08h", name, got, exp);
   endtask

   task automatic report_fail(input string name, input int got, input int exp);
      total_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   // Reference product from the IEEE rules: exact integer product, then
   // round-to-nearest-even by comparing the discarded remainder with one half ulp.
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      logic s;
      int ea, eb, e, sh;
      longint unsigned ma, mb, p, q, rem, half;
      bit an, ai, az, bn, bi, bz;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      az = (ea == 0);
      bz = (eb == 0);
      ai = (ea == 255) && (a[22:0] == 0);
      bi = (eb == 255) && (b[22:0] == 0);
      an = (ea == 255) && (a[22:0] != 0);
      bn = (eb == 255) && (b[22:0] != 0);
      if (an || bn || (ai && bz) || (bi && az)) return 32'h7FC0_0000;
      if (ai || bi) return {s, 8'hFF, 23'd0};
      if (az || bz) return {s, 31'd0};
      ma = 64'(a[22:0]) + (64'd1 << 23);
      mb = 64'(b[22:0]) + (64'd1 << 23);
      p  = ma * mb;
      e  = ea + eb - 127;
      if (p >= (64'd1 << 47)) begin
         sh = 24;
         e  = e + 1;
      end else begin
         sh = 23;
      end
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         e = e + 1;
      end
      if (e >= 255) return {s, 8'hFF, 23'd0};
      if (e <= 0) return {s, 31'd0};
      return {s, e[7:0], q[22:0]};
   endfunction

   function automatic logic [31:0] rand_fp();
      logic s;
      logic [7:0] e;
      logic [22:0] f;
      int r;
      s = 1'($urandom_range(0, 1));
      f = 23'($urandom);
      r = $urandom_range(0, 19);
      case (r)
         0:       e = 8'h00;
         1:       begin e = 8'hFF; f = 23'd0; end
         2:       begin e = 8'hFF; f = f | 23'd1; end
         3:       e = 8'($urandom_range(1, 254));
         4:       begin e = 8'($urandom_range(1, 254)); f = 23'h7FFFFF; end
         5:       begin e = 8'($urandom_range(120, 134)); f = 23'h7FFFFF; end
         default: e = 8'($urandom_range(110, 144));
      endcase
      return {s, e, f};
   endfunction

   // Present one pair at edge 0 with downstream ready; result must appear only after edge 3.
   task automatic lat_check(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                            input string name);
      a_data  = a;
      b_data  = b;
      a_valid = 1'b1;
      b_valid = 1'b1;
      @(posedge clk); #1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 3) begin
            check($sformatf("%s_valid_e%0d", name, k), 32'(m_valid), 32'd1);
            check($sformatf("%s_data", name), m_data, exp);
         end else begin
            check($sformatf("%s_valid_e%0d", name, k), 32'(m_valid), 32'd0);
         end
      end
      @(posedge clk); #1;
   endtask

   // Send one pair and wait (bounded) for its result.
   task automatic run_pair(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                           input string name);
      int n;
      a_data  = a;
      b_data  = b;
      a_valid = 1'b1;
      b_valid = 1'b1;
      @(posedge clk); #1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!m_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!m_valid) report_fail({name, "_timeout"}, n, 3);
      else check(name, m_data, exp);
      @(posedge clk); #1;
   endtask

   logic [31:0] qa[$];
   logic [31:0] qb[$];
   logic [31:0] qexp[$];
   logic [31:0] bp_b[5];
   int          res_cyc[5];

   initial begin
      int ia, ib, nres, nrecv, na_sent, nb_sent, cyc;
      bit acc_a, acc_b, held;
      logic [31:0] held_data;

      vecs[0]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002};
      vecs[1]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE};
      vecs[2]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000};
      vecs[3]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000};
      vecs[4]  = '{32'hFF800000, 32'h40000000, 32'hFF800000};
      vecs[5]  = '{32'h00800000, 32'h00800000, 32'h00000000};
      vecs[6]  = '{32'h80000000, 32'h3F800000, 32'h80000000};
      vecs[7]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000};
      vecs[8]  = '{32'h00000001, 32'h7F800000, 32'h7FC00000};
      vecs[9]  = '{32'h00800000, 32'h3F000000, 32'h00000000};
      vecs[10] = '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF};
      vecs[11] = '{32'h7F000000, 32'h40000000, 32'h7F800000};
      vecs[12] = '{32'hC0000000, 32'h3FC00000, 32'hC0400000};
      vecs[13] = '{32'h3F7FFFFF, 32'h3F800001, 32'h3F800000};
      vecs[14] = '{32'h80000000, 32'hFF800000, 32'h7FC00000};
      vecs[15] = '{32'h00800000, 32'h3F800000, 32'h00800000};
      vecs[16] = '{32'h3FC00001, 32'h3FC00000, 32'h40100001};
      vecs[17] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002};
      vecs[18] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004};

      bp_b[0] = 32'h3F800000;
      bp_b[1] = 32'h40000000;
      bp_b[2] = 32'h40400000;
      bp_b[3] = 32'h40800000;
      bp_b[4] = 32'h40A00000;

      // reset state
      rst     = 1'b1;
      a_data  = 32'd0;
      b_data  = 32'd0;
      a_valid = 1'b0;
      b_valid = 1'b0;
      m_ready = 1'b1;
      #2;
      check("rst_tvalid", 32'(m_valid), 32'd0);
      check("rst_tdata", m_data, 32'd0);
      check("rst_a_tready", 32'(a_ready), 32'd0);
      check("rst_b_tready", 32'(b_ready), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_a_tready", 32'(a_ready), 32'd1);
      check("post_rst_b_tready", 32'(b_ready), 32'd1);
      @(posedge clk); #1;

      // basic latency: 3.0 x 2.0
      lat_check(32'h40400000, 32'h40000000, 32'h40C00000, "lat");

      // skewed operands: A now, B five edges later
      a_data  = 32'h3FC00000;
      a_valid = 1'b1;
      @(posedge clk); #1;
      a_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("skew_a_tready_e%0d", k), 32'(a_ready), 32'd0);
         check($sformatf("skew_tvalid_e%0d", k), 32'(m_valid), 32'd0);
         @(posedge clk); #1;
         if (k == 3) begin
            b_data  = 32'h3FC00000;
            b_valid = 1'b1;
         end
         if (k == 4) b_valid = 1'b0;
      end
      for (int k = 5; k < 10; k++) begin
         @(negedge clk);
         if (k == 8) begin
            check("skew_tvalid_e8", 32'(m_valid), 32'd1);
            check("skew_tdata", m_data, 32'h40100000);
         end else begin
            check($sformatf("skew_tvalid_e%0d", k), 32'(m_valid), 32'd0);
         end
         @(posedge clk); #1;
      end

      // arithmetic corner-case table
      for (int i = 0; i < 19; i++) begin
         run_pair(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // backpressure: five pairs 1.0 x k with downstream stalled
      m_ready = 1'b0;
      ia = 0;
      ib = 0;
      nres = 0;
      a_data  = 32'h3F800000;
      b_data  = bp_b[0];
      a_valid = 1'b1;
      b_valid = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (c == 12) m_ready = 1'b1;
         @(negedge clk);
         acc_a = a_valid & a_ready;
         acc_b = b_valid & b_ready;
         if (m_valid && !m_ready) check($sformatf("bp_hold_c%0d", c), m_data, 32'h3F800000);
         if (c == 11) begin
            check("bp_stalled_a_tready", 32'(a_ready), 32'd0);
            check("bp_stalled_b_tready", 32'(b_ready), 32'd0);
            check("bp_accepted_before_release", 32'(ia), 32'd4);
            check("bp_tvalid_held", 32'(m_valid), 32'd1);
         end
         if (m_valid && m_ready) begin
            if (nres < 5) begin
               check($sformatf("bp_res%0d", nres), m_data, bp_b[nres]);
               res_cyc[nres] = c;
            end
            nres++;
         end
         @(posedge clk); #1;
         if (acc_a) begin
            ia++;
            if (ia >= 5) a_valid = 1'b0;
         end
         if (acc_b) begin
            ib++;
            if (ib < 5) b_data = bp_b[ib];
            else b_valid = 1'b0;
         end
      end
      check("bp_result_count", 32'(nres), 32'd5);
      if (nres >= 5) check("bp_one_per_cycle", 32'(res_cyc[4] - res_cyc[0]), 32'd4);

      // async reset with two operations in flight
      m_ready = 1'b0;
      a_data  = 32'h40000000;
      b_data  = 32'h40400000;
      a_valid = 1'b1;
      b_valid = 1'b1;
      @(posedge clk); #1;
      b_data  = 32'h40000000;
      @(posedge clk); #1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rstfly_tvalid_before", 32'(m_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("rstfly_tvalid_async", 32'(m_valid), 32'd0);
      check("rstfly_tdata_async", m_data, 32'd0);
      check("rstfly_a_tready", 32'(a_ready), 32'd0);
      check("rstfly_b_tready", 32'(b_ready), 32'd0);
      @(posedge clk); #3;
      rst     = 1'b0;
      m_ready = 1'b1;
      @(negedge clk);
      check("rstfly_a_tready_after", 32'(a_ready), 32'd1);
      check("rstfly_b_tready_after", 32'(b_ready), 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("rstfly_no_stale%0d", k), 32'(m_valid), 32'd0);
      end
      @(posedge clk); #1;
      lat_check(32'h40000000, 32'h40000000, 32'h40800000, "rstfly_lat");

      // randomized traffic with random valids and downstream stalls
      na_sent = 0;
      nb_sent = 0;
      nrecv   = 0;
      held    = 1'b0;
      held_data = 32'd0;
      cyc     = 0;
      while (nrecv < 300 && cyc < 5000) begin
         if (!a_valid && na_sent < 300 && $urandom_range(0, 3) != 0) begin
            a_valid = 1'b1;
            a_data  = rand_fp();
         end
         if (!b_valid && nb_sent < 300 && $urandom_range(0, 3) != 0) begin
            b_valid = 1'b1;
            b_data  = rand_fp();
         end
         m_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (held) begin
            check("rnd_hold_valid", 32'(m_valid), 32'd1);
            check("rnd_hold_data", m_data, held_data);
         end
         acc_a = a_valid & a_ready;
         acc_b = b_valid & b_ready;
         if (acc_a) begin
            qa.push_back(a_data);
            na_sent++;
         end
         if (acc_b) begin
            qb.push_back(b_data);
            nb_sent++;
         end
         while (qa.size() > 0 && qb.size() > 0) qexp.push_back(ref_mul(qa.pop_front(), qb.pop_front()));
         if (m_valid && m_ready) begin
            if (qexp.size() == 0) report_fail("rnd_spurious_result", 0, 1);
            else check($sformatf("rnd_res%0d", nrecv), m_data, qexp.pop_front());
            nrecv++;
         end
         held      = m_valid && !m_ready;
         held_data = m_data;
         @(posedge clk); #1;
         if (acc_a) a_valid = 1'b0;
         if (acc_b) b_valid = 1'b0;
         cyc++;
      end
      check("rnd_recv_count", 32'(nrecv), 32'd300);
      check("rnd_queue_empty", 32'(qexp.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
